// File: rtl/eth_cfg_loader.sv
// rtl/eth_cfg_loader.sv - snapshots MAC/IP/UDP ports and writes them into the Ethernet bridge config map
//
// Ports:
//   cfg_clk        clock
//   rst            synchronous active-high reset
//   mac/ip         station MAC (mac[47:40] first octet) and IPv4 address (ip[31:24] first octet)
//   udp_ports      NPORTS x 16-bit UDP ports, port n at [16n+15:16n]
//   rx_en_req      host request for receive enable
//   load           single-cycle (re)load request
//   cfg_valid      write strobe, one cycle per byte
//   cfg_addr       write address, [4]=0 MAC/IP bank, [4]=1 UDP bank
//   cfg_wdata      write byte
//   cfg_enable_rx  receive enable to the bridge
//   busy/done      sequence in progress / one-cycle completion pulse
//   load_count     completed sequences, wraps at 255
module eth_cfg_loader #(
    parameter int NPORTS      = 2,
    parameter int GAP         = 0,
    parameter int QUIESCE_CYC = 16,
    parameter int AUTO_LOAD   = 1
) (
    input  logic                  cfg_clk,
    input  logic                  rst,
    input  logic [47:0]           mac,
    input  logic [31:0]           ip,
    input  logic [16*NPORTS-1:0]  udp_ports,
    input  logic                  rx_en_req,
    input  logic                  load,
    output logic                  cfg_valid,
    output logic [4:0]            cfg_addr,
    output logic [7:0]            cfg_wdata,
    output logic                  cfg_enable_rx,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            load_count
);

    localparam logic [4:0] LAST_IDX = 5'(10 + 2 * NPORTS - 1);
    localparam logic [3:0] GAP_V    = 4'(GAP);
    localparam logic [7:0] Q_LAST   = 8'(QUIESCE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUIESCE  = 3'd1,
        WR_MACIP = 3'd2,
        WR_UDP   = 3'd3,
        FINISH   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    qcnt;
    logic [3:0]    gcnt;
    logic [4:0]    widx;
    logic          pend;
    logic          auto_req;
    logic [79:0]   macip_snap;
    logic [127:0]  ports_snap;

    logic          writing;
    logic          last_wr;
    logic          start;
    logic [3:0]    mi;
    logic [3:0]    uidx;

    logic          valid_d;
    logic [4:0]    addr_d;
    logic [7:0]    wdata_d;
    logic          en_d;
    logic          busy_d;
    logic          done_d;
    logic [7:0]    count_d;

    // A byte goes out whenever a write state has exhausted its inter-write gap.
    assign writing = ((state == WR_MACIP) || (state == WR_UDP)) && (gcnt == 4'd0);
    assign last_wr = writing && (widx == LAST_IDX);
    // A new sequence begins from IDLE on a request, or straight out of FINISH
    // when a request arrived during the previous sequence.
    assign start   = ((state == IDLE) && (load || auto_req)) ||
                     ((state == FINISH) && (pend || load));

    // MAC/IP bytes are stored first-octet-high, so byte k sits 9-k octets up.
    assign mi   = 4'd9 - widx[3:0];
    // UDP byte index relative to the start of the UDP bank (wraps correctly mod 16).
    assign uidx = widx[3:0] - 4'd10;

    always_ff @(posedge cfg_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (load || auto_req) state_nx = QUIESCE;
            QUIESCE:  if (qcnt == Q_LAST) state_nx = WR_MACIP;
            WR_MACIP: if (writing && widx == 5'd9) state_nx = WR_UDP;
            WR_UDP:   if (last_wr) state_nx = FINISH;
            FINISH:   state_nx = (pend || load) ? QUIESCE : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        valid_d = writing;
        addr_d  = cfg_addr;
        wdata_d = cfg_wdata;
        if (writing) begin
            if (widx < 5'd10) begin
                addr_d  = widx;
                wdata_d = macip_snap[{mi, 3'b000} +: 8];
            end else begin
                addr_d  = {1'b1, uidx};
                // Port n high byte is addressed first; its bit offset is 16n+8.
                wdata_d = ports_snap[{uidx[3:1], ~uidx[0], 3'b000} +: 8];
            end
        end
        busy_d  = (state == QUIESCE) || (state == WR_MACIP) || (state == WR_UDP);
        done_d  = (state == FINISH);
        count_d = load_count + {7'd0, state == FINISH};
        // FINISH is visible as the first idle cycle, unless another sequence
        // follows immediately, in which case reception stays quiesced.
        en_d    = rx_en_req && ((state == IDLE) ||
                                ((state == FINISH) && !pend && !load));
    end

    always_ff @(posedge cfg_clk) begin
        if (rst) begin
            qcnt          <= 8'd0;
            gcnt          <= 4'd0;
            widx          <= 5'd0;
            pend          <= 1'b0;
            auto_req      <= (AUTO_LOAD != 0);
            macip_snap    <= 80'd0;
            ports_snap    <= 128'd0;
            cfg_valid     <= 1'b0;
            cfg_addr      <= 5'd0;
            cfg_wdata     <= 8'd0;
            cfg_enable_rx <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            load_count    <= 8'd0;
        end else begin
            auto_req <= 1'b0;

            if (state == FINISH) begin
                pend <= 1'b0;
            end else if (load && state != IDLE) begin
                pend <= 1'b1;
            end

            if (start) begin
                macip_snap <= {mac, ip};
                ports_snap <= 128'(udp_ports);
                qcnt       <= 8'd0;
            end else if (state == QUIESCE) begin
                qcnt <= qcnt + 8'd1;
            end

            if (state == QUIESCE) begin
                gcnt <= 4'd0;
                widx <= 5'd0;
            end else if (state == WR_MACIP || state == WR_UDP) begin
                if (writing) begin
                    widx <= widx + 5'd1;
                    gcnt <= GAP_V;
                end else begin
                    gcnt <= gcnt - 4'd1;
                end
            end

            cfg_valid     <= valid_d;
            cfg_addr      <= addr_d;
            cfg_wdata     <= wdata_d;
            cfg_enable_rx <= en_d;
            busy          <= busy_d;
            done          <= done_d;
            load_count    <= count_d;
        end
    end

endmodule

// File: tb/tb_eth_cfg_loader.sv
// tb/tb_eth_cfg_loader.sv - self-checking bench for eth_cfg_loader
module tb_eth_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [47:0] d_mac;
    logic [31:0] d_ip;
    logic [31:0] d_ports;
    logic        d_rx, d_load;
    logic        d_valid, d_en, d_busy, d_done;
    logic [4:0]  d_addr;
    logic [7:0]  d_wdata, d_cnt_o;

    logic [47:0] g_mac;
    logic [31:0] g_ip;
    logic [47:0] g_ports;
    logic        g_rx, g_load;
    logic        g_valid, g_en, g_busy, g_done;
    logic [4:0]  g_addr;
    logic [7:0]  g_wdata, g_cnt_o;

    eth_cfg_loader #(.NPORTS(2), .GAP(0), .QUIESCE_CYC(16), .AUTO_LOAD(1)) dut (
        .cfg_clk(clk), .rst(rst), .mac(d_mac), .ip(d_ip), .udp_ports(d_ports),
        .rx_en_req(d_rx), .load(d_load), .cfg_valid(d_valid), .cfg_addr(d_addr),
        .cfg_wdata(d_wdata), .cfg_enable_rx(d_en), .busy(d_busy), .done(d_done),
        .load_count(d_cnt_o)
    );

    eth_cfg_loader #(.NPORTS(3), .GAP(3), .QUIESCE_CYC(5), .AUTO_LOAD(0)) dut_g (
        .cfg_clk(clk), .rst(rst), .mac(g_mac), .ip(g_ip), .udp_ports(g_ports),
        .rx_en_req(g_rx), .load(g_load), .cfg_valid(g_valid), .cfg_addr(g_addr),
        .cfg_wdata(g_wdata), .cfg_enable_rx(g_en), .busy(g_busy), .done(g_done),
        .load_count(g_cnt_o)
    );

    int sel = 0;
    logic       m_valid, m_en, m_busy, m_done;
    logic [4:0] m_addr;
    logic [7:0] m_wdata, m_cnt;
    assign m_valid = (sel == 1) ? g_valid : d_valid;
    assign m_en    = (sel == 1) ? g_en    : d_en;
    assign m_busy  = (sel == 1) ? g_busy  : d_busy;
    assign m_done  = (sel == 1) ? g_done  : d_done;
    assign m_addr  = (sel == 1) ? g_addr  : d_addr;
    assign m_wdata = (sel == 1) ? g_wdata : d_wdata;
    assign m_cnt   = (sel == 1) ? g_cnt_o : d_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_addr [32];
    logic [7:0] exp_data [32];
    int         exp_n;

    typedef struct {
        logic [47:0]  mac;
        logic [31:0]  ip;
        logic [31:0]  ports;
        logic         rx;
        logic [111:0] exp_bytes;
        logic         exp_en;
    } vec_t;
    vec_t tbl [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic set_load(input logic v);
        if (sel == 1) g_load = v; else d_load = v;
    endtask

    task automatic set_rx(input logic v);
        if (sel == 1) g_rx = v; else d_rx = v;
    endtask

    task automatic set_mac(input logic [47:0] v);
        if (sel == 1) g_mac = v; else d_mac = v;
    endtask

    task automatic start_load();
        set_load(1'b1);
        tick();
        set_load(1'b0);
    endtask

    // Expected write list straight from the address map: six MAC octets,
    // four IP octets, then each port high byte / low byte in the UDP bank.
    task automatic build_model(input logic [47:0] m, input logic [31:0] ipv,
                               input logic [127:0] pv, input int np);
        int n;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            exp_addr[n] = 5'(k);
            exp_data[n] = 8'(m >> (40 - 8 * k));
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            exp_addr[n] = 5'(6 + k);
            exp_data[n] = 8'(ipv >> (24 - 8 * k));
            n++;
        end
        for (int p = 0; p < np; p++) begin
            logic [15:0] port;
            port = 16'(pv >> (16 * p));
            exp_addr[n] = 5'(16 + 2 * p);
            exp_data[n] = port[15:8];
            n++;
            exp_addr[n] = 5'(17 + 2 * p);
            exp_data[n] = port[7:0];
            n++;
        end
        exp_n = n;
    endtask

    task automatic load_table_exp(input logic [111:0] b);
        logic [111:0] t;
        t = b;
        for (int i = 0; i < 14; i++) begin
            exp_data[i] = t[111 - 8 * i -: 8];
            exp_addr[i] = (i < 10) ? 5'(i) : 5'(16 + i - 10);
        end
        exp_n = 14;
    endtask

    // Called just after edge 0 (the edge that accepted the load). Walks to the
    // done edge, checking strobe timing, bytes, hold behaviour and completion.
    task automatic run_check(input int qc, input int gp, input int nload,
                             input int chg_idx, input logic [47:0] chg_mac,
                             input logic rx_final, input logic toggle_rx,
                             input logic exp_en, input logic [7:0] exp_cnt,
                             input string tag);
        int w, last, widx, bad_strobe, bad_done, bad_en, bad_hold;
        logic exp_v;
        logic [4:0] la;
        logic [7:0] ld;
        w = exp_n;
        last = 1 + qc + (w - 1) * (gp + 1);
        widx = 0; bad_strobe = 0; bad_done = 0; bad_en = 0; bad_hold = 0;
        la = 5'd0; ld = 8'd0;
        for (int e = 1; e <= last + 1; e++) begin
            tick();
            if (e == 1) chk($sformatf("start busy/en %s", tag), {m_busy, m_en}, 2'b10);
            if (e <= last) begin
                exp_v = (e >= 1 + qc) && (((e - 1 - qc) % (gp + 1)) == 0);
                if (m_valid !== exp_v) bad_strobe++;
                if (m_done !== 1'b0) bad_done++;
                if (m_en !== 1'b0 || m_busy !== 1'b1) bad_en++;
                if (m_valid === 1'b1 && exp_v && widx < w) begin
                    chk($sformatf("write%0d addr/data %s", widx, tag),
                        {m_addr, m_wdata}, {exp_addr[widx], exp_data[widx]});
                    la = m_addr;
                    ld = m_wdata;
                    widx++;
                    if (widx == chg_idx + 1) set_mac(chg_mac);
                end else if (widx > 0 && (m_addr !== la || m_wdata !== ld)) begin
                    bad_hold++;
                end
            end
            set_load((e % 3 == 0) && (e / 3 <= nload) && (e < last));
            if (toggle_rx) set_rx((e < last) ? 1'($urandom % 2) : rx_final);
        end
        set_load(1'b0);
        chk($sformatf("writes seen %s", tag), widx, w);
        chk($sformatf("strobe timing errs %s", tag), bad_strobe, 0);
        chk($sformatf("early done errs %s", tag), bad_done, 0);
        chk($sformatf("busy/en during seq errs %s", tag), bad_en, 0);
        chk($sformatf("addr/data hold errs %s", tag), bad_hold, 0);
        chk($sformatf("done %s", tag), m_done, 1'b1);
        chk($sformatf("busy at done %s", tag), m_busy, 1'b0);
        chk($sformatf("load_count %s", tag), m_cnt, exp_cnt);
        chk($sformatf("enable_rx at done %s", tag), m_en, exp_en);
    endtask

    task automatic check_reset_vals(input string tag);
        chk($sformatf("rst cfg_valid %s", tag), d_valid, 1'b0);
        chk($sformatf("rst cfg_addr %s", tag), d_addr, 5'd0);
        chk($sformatf("rst cfg_wdata %s", tag), d_wdata, 8'd0);
        chk($sformatf("rst enable_rx %s", tag), d_en, 1'b0);
        chk($sformatf("rst busy %s", tag), d_busy, 1'b0);
        chk($sformatf("rst done %s", tag), d_done, 1'b0);
        chk($sformatf("rst load_count %s", tag), d_cnt_o, 8'd0);
        chk($sformatf("rst gap dut %s", tag), {g_valid, g_busy, g_cnt_o}, 10'd0);
    endtask

    initial begin
        int d_cnt, g_cnt, nv, bad;
        logic seen;
        logic rxf;

        tbl[0] = '{48'h125555_00012E, 32'hC0A801AD, 32'h1F90_0BB8, 1'b1,
                   112'h125555_00012E_C0A801AD_0BB8_1F90, 1'b1};
        tbl[1] = '{48'h020000_000001, 32'h0A000001, 32'hFFFF_0035, 1'b0,
                   112'h020000_000001_0A000001_0035_FFFF, 1'b0};
        tbl[2] = '{48'hFFFFFF_FFFFFF, 32'h00000000, 32'hABCD_1234, 1'b1,
                   112'hFFFFFF_FFFFFF_00000000_1234_ABCD, 1'b1};

        rst = 1'b1;
        d_mac = tbl[0].mac; d_ip = tbl[0].ip; d_ports = tbl[0].ports;
        d_rx = 1'b1; d_load = 1'b0;
        g_mac = 48'h0; g_ip = 32'h0; g_ports = 48'h0; g_rx = 1'b1; g_load = 1'b0;
        sel = 0;
        repeat (3) tick();
        check_reset_vals("initial");

        // Auto-load after reset release: edge 0 is the first edge with rst low.
        rst = 1'b0;
        tick();
        load_table_exp(tbl[0].exp_bytes);
        run_check(16, 0, 0, -1, 48'h0, 1'b1, 1'b0, tbl[0].exp_en, 8'd1, "auto tbl0");
        d_cnt = 1;

        for (int i = 1; i < 3; i++) begin
            d_mac = tbl[i].mac; d_ip = tbl[i].ip; d_ports = tbl[i].ports; d_rx = tbl[i].rx;
            load_table_exp(tbl[i].exp_bytes);
            start_load();
            d_cnt++;
            run_check(16, 0, 0, -1, 48'h0, tbl[i].rx, 1'b0, tbl[i].exp_en, 8'(d_cnt),
                      $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            d_mac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            d_ip = $urandom; d_ports = $urandom;
            rxf = 1'($urandom % 2);
            build_model(d_mac, d_ip, 128'(d_ports), 2);
            start_load();
            d_cnt++;
            run_check(16, 0, 0, -1, 48'h0, rxf, 1'b1, rxf, 8'(d_cnt), $sformatf("rand%0d", i));
        end

        // MAC changes after the 5th write: current sequence keeps the snapshot.
        d_rx = 1'b1;
        d_mac = 48'h125555_00012E; d_ip = 32'hC0A801AD; d_ports = 32'h1F90_0BB8;
        build_model(d_mac, d_ip, 128'(d_ports), 2);
        start_load();
        d_cnt++;
        run_check(16, 0, 0, 4, 48'h020000_000001, 1'b1, 1'b0, 1'b1, 8'(d_cnt), "mac snap");
        chk("mac input changed", d_mac, 48'h020000_000001);
        build_model(d_mac, d_ip, 128'(d_ports), 2);
        start_load();
        d_cnt++;
        run_check(16, 0, 0, -1, 48'h0, 1'b1, 1'b0, 1'b1, 8'(d_cnt), "mac new");

        // Three loads while busy merge into one back-to-back sequence.
        start_load();
        d_cnt++;
        run_check(16, 0, 3, -1, 48'h0, 1'b1, 1'b0, 1'b0, 8'(d_cnt), "merged a");
        d_cnt++;
        run_check(16, 0, 0, -1, 48'h0, 1'b1, 1'b0, 1'b1, 8'(d_cnt), "merged b");
        tick();
        chk("no third sequence", {d_busy, d_valid}, 2'b00);

        // Reset at the 8th write aborts; auto-load then restarts.
        start_load();
        nv = 0;
        for (int c = 0; c < 100 && nv < 8; c++) begin
            tick();
            if (d_valid) nv++;
        end
        chk("reached 8th write", nv, 8);
        rst = 1'b1;
        tick();
        check_reset_vals("mid-seq");
        bad = 0;
        repeat (2) begin
            tick();
            if (d_valid !== 1'b0 || d_busy !== 1'b0) bad++;
        end
        chk("quiet while in reset", bad, 0);
        rst = 1'b0;
        tick();
        d_cnt = 1;
        g_cnt = 0;
        run_check(16, 0, 0, -1, 48'h0, 1'b1, 1'b0, 1'b1, 8'(d_cnt), "restart");

        // GAP=3 instance: randomized contents, rx_en_req toggling while busy.
        sel = 1;
        for (int i = 0; i < 4; i++) begin
            g_mac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            g_ip = $urandom; g_ports = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            rxf = 1'($urandom % 2);
            build_model(g_mac, g_ip, 128'(g_ports), 3);
            start_load();
            g_cnt++;
            run_check(5, 3, 0, -1, 48'h0, rxf, 1'b1, rxf, 8'(g_cnt), $sformatf("gap%0d", i));
        end

        // load_count wrap.
        sel = 0;
        d_rx = 1'b1;
        build_model(d_mac, d_ip, 128'(d_ports), 2);
        while (d_cnt != 255) begin
            start_load();
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                tick();
                if (d_done) seen = 1'b1;
            end
            if (!seen) begin
                chk("done timeout", seen, 1'b1);
                break;
            end
            d_cnt++;
        end
        chk("load_count at 255", d_cnt_o, 8'd255);
        start_load();
        run_check(16, 0, 0, -1, 48'h0, 1'b1, 1'b0, 1'b1, 8'd0, "wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_cfg_loader.md
# eth_cfg_loader

Configuration initiator that drives the Ethernet configuration write port (`cfg_valid`/`cfg_addr`/`cfg_wdata`/`cfg_enable_rx`) of the GTX Ethernet bridge. It snapshots the station MAC, the IP address and a table of UDP port numbers. It then quiesces the receive path and writes every configuration byte in the bridge's address map. Finally it re-enables reception. It sits in the `cfg_clk` domain next to the bridge and replaces ad-hoc host writes at boot and on address changes.

## Interface
Parameters:
- `NPORTS`, 2: number of UDP port entries written; valid range 1..8.
- `GAP`, 0: idle cycles inserted between consecutive writes; valid range 0..15.
- `QUIESCE_CYC`, 16: cycles `cfg_enable_rx` is held low before the first write; valid range 1..255.
- `AUTO_LOAD`, 1: when 1, a load sequence starts automatically after reset is released.

Ports (clock and reset first):
- `cfg_clk`  in  1: the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `mac`  in  48: station MAC; `mac[47:40]` is the first octet on the wire.
- `ip`  in  32: IPv4 address; `ip[31:24]` is the first octet.
- `udp_ports`  in  16*NPORTS: port n occupies `udp_ports[16n+15:16n]`.
- `rx_en_req`  in  1: host request for the receive path to be enabled.
- `load`  in  1: single-cycle request to (re)load the configuration.
- `cfg_valid`  out  1: write strobe, 1 cycle per byte.
- `cfg_addr`  out  5: write address; `[4]`=0 selects MAC/IP, `[4]`=1 selects UDP ports.
- `cfg_wdata`  out  8: write byte.
- `cfg_enable_rx`  out  1: receive enable to the bridge.
- `busy`  out  1: high from the cycle after a load is accepted until done.
- `done`  out  1: 1-cycle pulse when a sequence completes.
- `load_count`  out  8: completed sequences; wraps at 255 -> 0.

## Operation
- States: IDLE, QUIESCE, WR_MACIP, WR_UDP, FINISH.
- IDLE -> QUIESCE on an accepted `load`. Also IDLE -> QUIESCE on the first cycle after `rst` falls when `AUTO_LOAD`=1.
- On entry to QUIESCE, `mac`, `ip` and `udp_ports` are snapshotted into internal registers. Input changes after that point affect only the next sequence.
- QUIESCE holds for exactly `QUIESCE_CYC` cycles, then moves to WR_MACIP.
- WR_MACIP writes 10 bytes at addresses 0..9:
  - addr k (0..5) = MAC octet k, where addr 0 = `mac[47:40]` and addr 5 = `mac[7:0]`.
  - addr 6..9 = `ip[31:24]`, `ip[23:16]`, `ip[15:8]`, `ip[7:0]`.
  - All with `cfg_addr[4]`=0.
- WR_UDP writes 2*NPORTS bytes with `cfg_addr[4]`=1:
  - addr 2n = port n `[15:8]`.
  - addr 2n+1 = port n `[7:0]`.
- FINISH lasts 1 cycle: `done`=1, `load_count` increments, next state IDLE.
- `cfg_enable_rx` = `rx_en_req` AND state==IDLE, registered.
- A `load` arriving while `busy` is pended in a 1-bit flag. Additional loads during the same busy period merge into that flag. A pending load starts a new QUIESCE in the cycle after FINISH, and IDLE lasts 0 cycles.
- A `load` arriving in the FINISH cycle is pended in the same way.

## Timing
- Reset values: `cfg_valid`=0, `cfg_addr`=0, `cfg_wdata`=0, `cfg_enable_rx`=0, `busy`=0, `done`=0, `load_count`=0, state IDLE, pending flag 0.
- Reset asserted mid-sequence aborts the sequence immediately. No further `cfg_valid` appears, and all outputs take their reset values on the next edge.
- All outputs are registered. `load` is sampled at edge 0 and sets `busy`=1 and `cfg_enable_rx`=0 at edge 1.
- The first `cfg_valid` occurs at edge 1+QUIESCE_CYC.
- Writes are spaced GAP+1 cycles apart. `cfg_addr` and `cfg_wdata` are valid only while `cfg_valid`=1 and hold their last value otherwise.
- Total writes W = 10 + 2*NPORTS. The last write is at edge 1+QUIESCE_CYC+(W-1)(GAP+1).
- `done` pulses at the edge following the last write. At that same edge `busy` falls, `load_count` updates, and `cfg_enable_rx` rises if `rx_en_req`=1.
- `rx_en_req` toggling while busy has no effect until IDLE is reached.
- The MAC/IP and UDP phases are contiguous: there is no extra gap beyond GAP between addr 9 and the first UDP write.

## Test plan
- Reset released with AUTO_LOAD=1, NPORTS=2, GAP=0, QUIESCE_CYC=16, mac=12:55:55:00:01:2E, ip=C0A801AD, ports=0x0BB8/0x1F90, `rx_en_req`=1 -> writes at cycles 17..30:
  - bytes 12,55,55,00,01,2E,C0,A8,01,AD at addr 0x00..0x09;
  - bytes 0B,B8,1F,90 at addr 0x10..0x13;
  - `done` at cycle 31, `cfg_enable_rx`=1 at cycle 31, `load_count`=1.
- GAP=3 -> consecutive `cfg_valid` exactly 4 cycles apart; `cfg_addr`/`cfg_wdata` are stable between strobes.
- `mac` changed to 02:00:00:00:00:01 at the 5th write -> the current sequence still writes 12:55:55:..., and the next `load` writes the new value.
- Three `load` pulses during one busy period -> exactly one further sequence, started with 0 IDLE cycles; `load_count` advances by 2 in total.
- `rst` pulsed at the 8th write -> `cfg_valid` is never asserted again until the next sequence; all outputs show reset values; with AUTO_LOAD=1 a full sequence then restarts.
- `load_count` preloaded to 255 by running 255 sequences, plus one more -> `load_count`=0.
